// File: rtl/sdio_rbuf_sched.sv
// sdio_rbuf_sched
//   Sys_clk-side scheduler for the two-entry SD read ping-pong buffer.
//   It waits for the current buffer to report ready, streams its bytes
//   into the DMA write port, releases the buffer with a one-cycle free
//   pulse and then alternates to the other buffer. It keeps going until
//   the card-side data phase has ended and no further buffer is ready.
//
// Ports
//   sys_clk, rstn         clock, asynchronous active-low reset
//   sys_rst               synchronous soft reset (same effect as rstn)
//   auto_start, abort     session start / terminate pulses
//   blk_len               bytes per buffer (0 means 2**AW), sampled entering XFER
//   buf0/1_rd_rdy         buffer-full levels (already synchronised)
//   dat_done              card data phase complete pulse
//   buf_rd_en/sel/addr    buffer RAM read port; buf_rd_data returns 1 cycle later
//   dma_busy              DMA cannot accept new reads (stalls issue only)
//   dma_wr, dma_wdata     byte strobe/data into the DMA
//   buf_free              release pulse for buffer buf_rd_sel
//   dma_buf_empty         no byte in flight and not transferring
//   xfer_done, busy       normal session end pulse, state != IDLE
module sdio_rbuf_sched #(
    parameter int AW   = 9,
    parameter int HOLD = 8
) (
    input  logic          sys_clk,
    input  logic          rstn,
    input  logic          sys_rst,
    input  logic          auto_start,
    input  logic          abort,
    input  logic [AW:0]   blk_len,
    input  logic          buf0_rd_rdy,
    input  logic          buf1_rd_rdy,
    input  logic          dat_done,
    output logic          buf_rd_en,
    output logic          buf_rd_sel,
    output logic [AW-1:0] buf_rd_addr,
    input  logic [7:0]    buf_rd_data,
    input  logic          dma_busy,
    output logic          dma_wr,
    output logic [7:0]    dma_wdata,
    output logic          buf_free,
    output logic          dma_buf_empty,
    output logic          xfer_done,
    output logic          busy
);

    localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_XFER,
        S_DRAIN,
        S_FREE,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          cur_buf, cur_buf_nxt;
    logic          done_flag, done_flag_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [AW:0]   count, count_nxt;
    logic [HW-1:0] hold0, hold0_nxt;
    logic [HW-1:0] hold1, hold1_nxt;
    logic          wr_pend;
    logic          rdy_sel;
    logic [HW-1:0] hold_sel;
    logic [AW:0]   len_load;

    assign rdy_sel  = cur_buf ? buf1_rd_rdy : buf0_rd_rdy;
    assign hold_sel = cur_buf ? hold1 : hold0;
    // blk_len of zero encodes a full 2**AW byte buffer
    assign len_load = (blk_len == '0) ? {1'b1, {AW{1'b0}}} : blk_len;

    always_comb begin
        state_nxt     = state;
        cur_buf_nxt   = cur_buf;
        done_flag_nxt = done_flag;
        addr_nxt      = addr;
        count_nxt     = count;
        hold0_nxt     = (hold0 != '0) ? hold0 - 1'b1 : hold0;
        hold1_nxt     = (hold1 != '0) ? hold1 - 1'b1 : hold1;
        buf_free      = 1'b0;
        xfer_done     = 1'b0;
        // A read issued in the abort cycle is still in flight and completes.
        buf_rd_en     = (state == S_XFER) && !dma_busy;

        if (state != S_IDLE && dat_done)
            done_flag_nxt = 1'b1;

        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (auto_start) begin
                        done_flag_nxt = 1'b0;
                        cur_buf_nxt   = 1'b0;
                        state_nxt     = S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (rdy_sel && hold_sel == '0) begin
                        count_nxt = len_load;
                        addr_nxt  = '0;
                        state_nxt = S_XFER;
                    end else if (done_flag) begin
                        state_nxt = S_DONE;
                    end
                end
                S_XFER: begin
                    if (!dma_busy) begin
                        // address parks on the last byte instead of wrapping
                        if (count == {{AW{1'b0}}, 1'b1}) begin
                            state_nxt = S_DRAIN;
                        end else begin
                            addr_nxt  = addr + 1'b1;
                            count_nxt = count - 1'b1;
                        end
                    end
                end
                S_DRAIN: state_nxt = S_FREE;
                S_FREE: begin
                    buf_free = 1'b1;
                    if (cur_buf) hold1_nxt = HW'(HOLD);
                    else         hold0_nxt = HW'(HOLD);
                    cur_buf_nxt = ~cur_buf;
                    state_nxt   = S_WAIT_RDY;
                end
                S_DONE: begin
                    xfer_done = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cur_buf   <= 1'b0;
            done_flag <= 1'b0;
            addr      <= '0;
            count     <= '0;
            hold0     <= '0;
            hold1     <= '0;
            wr_pend   <= 1'b0;
        end else if (sys_rst) begin
            state     <= S_IDLE;
            cur_buf   <= 1'b0;
            done_flag <= 1'b0;
            addr      <= '0;
            count     <= '0;
            hold0     <= '0;
            hold1     <= '0;
            wr_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_buf   <= cur_buf_nxt;
            done_flag <= done_flag_nxt;
            addr      <= addr_nxt;
            count     <= count_nxt;
            hold0     <= hold0_nxt;
            hold1     <= hold1_nxt;
            wr_pend   <= buf_rd_en;
        end
    end

    assign buf_rd_sel    = cur_buf;
    assign buf_rd_addr   = addr;
    assign dma_wr        = wr_pend;
    assign dma_wdata     = buf_rd_data;
    assign busy          = (state != S_IDLE);
    assign dma_buf_empty = !wr_pend &&
                           (state == S_IDLE || state == S_WAIT_RDY || state == S_DONE);

endmodule
